buffer_sequencer: RTL and testbench

BUFFER_SEQUENCER -- requirements
Module: buffer_sequencer

---
 rtl/qoi_ctrl_pkg.sv | 25 ++
 rtl/cycle_timer.sv | 37 +++
 rtl/buffer_sequencer.sv | 145 ++++++++++++++
 tb/tb_buffer_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qoi_ctrl_pkg.sv
// Shared definitions for the buffer sequencer: state encoding,
// register map and CTRL/STATUS bit positions.
package qoi_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FILL  = 3'd0,
      ST_ARM   = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_ERROR = 3'd4
   } state_e;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_LEN_LO = 2'd2;
   localparam logic [1:0] REG_LEN_HI = 2'd3;

   localparam int CTRL_START  = 0;
   localparam int CTRL_ACK    = 1;
   localparam int CTRL_IRQ_EN = 2;

   localparam int STAT_IRQ = 3;
   localparam int STAT_ERR = 4;

endpackage

// File: rtl/cycle_timer.sv
// Saturating cycle counter; expired flags the last allowed cycle
// before the limit is reached.
module cycle_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         enable,
   input  logic [W-1:0] limit,
   output logic         expired
);

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && (cnt_q != '1)) begin
         cnt_d = cnt_q + ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q >= (limit - ONE));

endmodule

// File: rtl/buffer_sequencer.sv
// Ping-pong ownership sequencer between the CPU and a processing
// engine over a shared buffer, with a small register port.
module buffer_sequencer
   import qoi_ctrl_pkg::*;
#(
   parameter logic [15:0] TIMEOUT = 16'd65535,
   parameter int          ADDR_W  = 10
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cpu_cs,
   input  logic            cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic            fill_flag,
   output logic            cpu_cs_o,
   input  logic            eng_cs,
   input  logic            eng_we,
   output logic            eng_cs_o,
   output logic            sel,
   input  logic            ctrl_cs,
   input  logic            ctrl_we,
   input  logic [1:0]      ctrl_addr,
   input  logic [7:0]      ctrl_data_i,
   output logic [7:0]      ctrl_data_o,
   output logic            eng_start,
   input  logic            eng_done,
   output logic [ADDR_W:0] eng_len,
   output logic            irq
);

   localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

   state_e          state_q, state_d;
   logic            sel_q;
   logic [ADDR_W:0] len_q, len_d;
   logic            pend_q, pend_d;
   logic            en_q, en_d;
   logic            tmr_clr, tmr_en, tmr_exp;
   logic            ctrl_wr, start, ack;
   logic [ADDR_W:0] wr_len;
   logic [15:0]     len_ext;
   logic            unused_bits;

   assign ctrl_wr = ctrl_cs & ctrl_we & (ctrl_addr == REG_CTRL);
   assign start   = ctrl_wr & ctrl_data_i[CTRL_START];
   assign ack     = ctrl_wr & ctrl_data_i[CTRL_ACK];
   assign wr_len  = {1'b0, cpu_addr} + LEN_ONE;
   assign tmr_en  = (state_q == ST_RUN);

   cycle_timer #(.W(16)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (tmr_clr),
      .enable  (tmr_en),
      .limit   (TIMEOUT),
      .expired (tmr_exp)
   );

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      pend_d    = pend_q;
      en_d      = en_q;
      tmr_clr   = 1'b0;
      eng_start = 1'b0;
      if (ctrl_wr) begin
         en_d = ctrl_data_i[CTRL_IRQ_EN];
      end
      unique case (state_q)
         ST_FILL: begin
            if (cpu_cs && cpu_we && (wr_len > len_q)) begin
               len_d = wr_len;
            end
            if (fill_flag || start) begin
               state_d = ST_ARM;
               tmr_clr = 1'b1;
            end
         end
         ST_ARM: begin
            eng_start = 1'b1;
            state_d   = ST_RUN;
         end
         ST_RUN: begin
            // completion beats a coincident watchdog expiry
            if (eng_done) begin
               state_d = ST_DRAIN;
               pend_d  = 1'b1;
            end else if (tmr_exp) begin
               state_d = ST_ERROR;
               pend_d  = 1'b1;
            end
         end
         ST_DRAIN, ST_ERROR: begin
            if (ack) begin
               state_d = ST_FILL;
               len_d   = '0;
               pend_d  = 1'b0;
            end
         end
         default: begin
            state_d = ST_FILL;
            len_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_FILL;
         sel_q   <= 1'b0;
         len_q   <= '0;
         pend_q  <= 1'b0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= (state_d == ST_ARM) || (state_d == ST_RUN);
         len_q   <= len_d;
         pend_q  <= pend_d;
         en_q    <= en_d;
      end
   end

   assign sel      = sel_q;
   assign cpu_cs_o = cpu_cs & ~sel_q;
   assign eng_cs_o = eng_cs & sel_q;
   assign eng_len  = len_q;
   assign irq      = pend_q & en_q;
   assign len_ext  = 16'(len_q);

   always_comb begin
      ctrl_data_o = 8'h00;
      unique case (ctrl_addr)
         REG_CTRL:   ctrl_data_o[CTRL_IRQ_EN] = en_q;
         REG_STATUS: ctrl_data_o = {3'b000,
                                    state_q == ST_ERROR,
                                    pend_q, state_q};
         REG_LEN_LO: ctrl_data_o = len_ext[7:0];
         REG_LEN_HI: ctrl_data_o = {5'b00000, len_ext[10:8]};
         default:    ctrl_data_o = 8'h00;
      endcase
   end

   assign unused_bits = ^{eng_we, ctrl_data_i[7:3], len_ext[15:11]};

endmodule

// File: tb/tb_buffer_sequencer.sv
// Self-checking bench: vector table, directed corner cases and
// randomized traffic against a behavioural model of two instances.
module tb_buffer_sequencer;

   localparam int FILL = 0, ARM = 1, RUN = 2, DRAIN = 3, ERR = 4;

   logic clk;
   logic rst;
   logic cpu_cs, cpu_we, fill_flag;
   logic [9:0] cpu_addr;
   logic eng_cs, eng_we, eng_done;
   logic ctrl_cs, ctrl_we;
   logic [1:0] ctrl_addr;
   logic [7:0] ctrl_data_i;

   logic        cpu_cs_w[2];
   logic        eng_cs_w[2];
   logic        sel_w[2];
   logic [7:0]  cdo_w[2];
   logic        start_w[2];
   logic [10:0] len_w[2];
   logic        irq_w[2];

   int total = 0;
   int bad   = 0;

   int mst[2], mlen[2], mrun[2];
   bit mpend[2], men[2];
   int tmo[2];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   buffer_sequencer #(.TIMEOUT(16'd32), .ADDR_W(10)) dut_a (
      .clk(clk), .rst(rst),
      .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .fill_flag(fill_flag), .cpu_cs_o(cpu_cs_w[0]),
      .eng_cs(eng_cs), .eng_we(eng_we), .eng_cs_o(eng_cs_w[0]),
      .sel(sel_w[0]),
      .ctrl_cs(ctrl_cs), .ctrl_we(ctrl_we), .ctrl_addr(ctrl_addr),
      .ctrl_data_i(ctrl_data_i), .ctrl_data_o(cdo_w[0]),
      .eng_start(start_w[0]), .eng_done(eng_done),
      .eng_len(len_w[0]), .irq(irq_w[0])
   );

   buffer_sequencer #(.TIMEOUT(16'd16), .ADDR_W(10)) dut_b (
      .clk(clk), .rst(rst),
      .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .fill_flag(fill_flag), .cpu_cs_o(cpu_cs_w[1]),
      .eng_cs(eng_cs), .eng_we(eng_we), .eng_cs_o(eng_cs_w[1]),
      .sel(sel_w[1]),
      .ctrl_cs(ctrl_cs), .ctrl_we(ctrl_we), .ctrl_addr(ctrl_addr),
      .ctrl_data_i(ctrl_data_i), .ctrl_data_o(cdo_w[1]),
      .eng_start(start_w[1]), .eng_done(eng_done),
      .eng_len(len_w[1]), .irq(irq_w[1])
   );

   task automatic chk(string n, int unsigned act, int unsigned exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)",
                  n, act, exp, $time);
      end
   endtask

   function automatic int mread(int i, int a);
      case (a)
         0: return men[i] ? 4 : 0;
         1: return ((mst[i] == ERR) ? 16 : 0) +
                   (mpend[i] ? 8 : 0) + mst[i];
         2: return mlen[i] % 256;
         default: return mlen[i] / 256;
      endcase
   endfunction

   task automatic model_step(int i);
      bit wr, st, ak;
      int a;
      wr = ctrl_cs && ctrl_we && (ctrl_addr == 2'd0);
      st = wr && ctrl_data_i[0];
      ak = wr && ctrl_data_i[1];
      a  = int'(cpu_addr);
      if (!rst) begin
         mst[i] = FILL; mlen[i] = 0; mrun[i] = 0;
         mpend[i] = 0; men[i] = 0;
         return;
      end
      if (wr) men[i] = ctrl_data_i[2];
      case (mst[i])
         FILL: begin
            if (cpu_cs && cpu_we && (a + 1 > mlen[i])) mlen[i] = a + 1;
            if (fill_flag || st) mst[i] = ARM;
         end
         ARM: begin
            mst[i] = RUN;
            mrun[i] = 0;
         end
         RUN: begin
            mrun[i]++;
            if (eng_done) begin
               mst[i] = DRAIN; mpend[i] = 1;
            end else if (mrun[i] == tmo[i]) begin
               mst[i] = ERR; mpend[i] = 1;
            end
         end
         default: begin
            if (ak) begin
               mst[i] = FILL; mlen[i] = 0; mpend[i] = 0;
            end
         end
      endcase
   endtask

   task automatic check_model();
      for (int i = 0; i < 2; i++) begin
         bit s;
         string p;
         p = (i == 0) ? "a" : "b";
         s = (mst[i] == ARM) || (mst[i] == RUN);
         chk({p, ".sel"}, sel_w[i], s);
         chk({p, ".eng_start"}, start_w[i], mst[i] == ARM);
         chk({p, ".irq"}, irq_w[i], mpend[i] && men[i]);
         chk({p, ".eng_len"}, len_w[i], mlen[i]);
         chk({p, ".cpu_cs_o"}, cpu_cs_w[i], cpu_cs && !s);
         chk({p, ".eng_cs_o"}, eng_cs_w[i], eng_cs && s);
         chk({p, ".rdata"}, cdo_w[i], mread(i, int'(ctrl_addr)));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      check_model();
   endtask

   task automatic idle();
      rst = 1'b1; cpu_cs = 0; cpu_we = 0; cpu_addr = '0;
      fill_flag = 0; eng_cs = 0; eng_we = 0; eng_done = 0;
      ctrl_cs = 0; ctrl_we = 0; ctrl_addr = 2'd0; ctrl_data_i = 8'h00;
   endtask

   task automatic cpu_wr(int a, bit flag);
      cpu_cs = 1; cpu_we = 1; cpu_addr = 10'(a); fill_flag = flag;
      tick();
      idle();
   endtask

   task automatic ctrl_wr(logic [7:0] d);
      ctrl_cs = 1; ctrl_we = 1; ctrl_addr = 2'd0; ctrl_data_i = d;
      tick();
      idle();
   endtask

   task automatic done_pulse();
      eng_done = 1;
      tick();
      idle();
   endtask

   task automatic rd(int i, logic [1:0] a, string n, int exp);
      ctrl_addr = a;
      #1;
      chk(n, cdo_w[i], exp);
      ctrl_addr = 2'd0;
   endtask

   typedef struct {
      logic       rst;
      logic       cw;
      logic [9:0] a;
      logic       cc;
      logic [7:0] d;
      logic       done;
      logic       e_sel;
      logic       e_start;
      logic [10:0] e_len;
      logic [7:0] e_stat;
   } vec_t;

   vec_t vt[11];
   int pulses;

   initial begin
      tmo[0] = 32; tmo[1] = 16;
      for (int i = 0; i < 2; i++) begin
         mst[i] = FILL; mlen[i] = 0; mrun[i] = 0;
         mpend[i] = 0; men[i] = 0;
      end
      idle();
      rst = 1'b0;

      vt[0]  = '{0, 0, 10'd0,   0, 8'h00, 0, 0, 0, 11'd0,  8'h00};
      vt[1]  = '{1, 1, 10'd5,   0, 8'h00, 0, 0, 0, 11'd6,  8'h00};
      vt[2]  = '{1, 1, 10'd2,   0, 8'h00, 0, 0, 0, 11'd6,  8'h00};
      vt[3]  = '{1, 1, 10'd9,   1, 8'h01, 0, 1, 1, 11'd10, 8'h01};
      vt[4]  = '{1, 0, 10'd0,   0, 8'h00, 0, 1, 0, 11'd10, 8'h02};
      vt[5]  = '{1, 0, 10'd0,   0, 8'h00, 1, 0, 0, 11'd10, 8'h0B};
      vt[6]  = '{1, 0, 10'd0,   1, 8'h01, 0, 0, 0, 11'd10, 8'h0B};
      vt[7]  = '{1, 1, 10'd300, 0, 8'h00, 0, 0, 0, 11'd10, 8'h0B};
      vt[8]  = '{1, 0, 10'd0,   1, 8'h02, 0, 0, 0, 11'd0,  8'h00};
      vt[9]  = '{1, 0, 10'd0,   1, 8'h02, 0, 0, 0, 11'd0,  8'h00};
      vt[10] = '{1, 0, 10'd0,   0, 8'h00, 1, 0, 0, 11'd0,  8'h00};

      for (int k = 0; k < 11; k++) begin
         rst = vt[k].rst;
         cpu_cs = vt[k].cw; cpu_we = vt[k].cw; cpu_addr = vt[k].a;
         ctrl_cs = vt[k].cc; ctrl_we = vt[k].cc;
         ctrl_data_i = vt[k].d; eng_done = vt[k].done;
         tick();
         idle();
         chk($sformatf("vec%0d.sel", k), sel_w[0], vt[k].e_sel);
         chk($sformatf("vec%0d.start", k), start_w[0], vt[k].e_start);
         chk($sformatf("vec%0d.len", k), len_w[0], vt[k].e_len);
         rd(0, 2'd1, $sformatf("vec%0d.status", k), vt[k].e_stat);
      end

      // full buffer fill ending on the last address
      for (int a = 0; a < 1024; a++) cpu_wr(a, a == 1023);
      chk("full.start", start_w[0], 1);
      chk("full.sel", sel_w[0], 1);
      chk("full.len", len_w[0], 11'h400);
      rd(0, 2'd3, "full.len_hi", 8'h04);
      tick();
      chk("full.start_gone", start_w[0], 0);
      chk("full.sel_run", sel_w[0], 1);
      done_pulse();
      ctrl_wr(8'h02);

      // partial fill + START, then RUN isolation and reset
      for (int a = 0; a < 256; a++) cpu_wr(a, 0);
      ctrl_wr(8'h01);
      chk("part.len", len_w[0], 11'h100);
      rd(0, 2'd3, "part.len_hi", 8'h01);
      rd(0, 2'd2, "part.len_lo", 8'h00);
      tick();
      cpu_cs = 1; eng_cs = 1;
      #1;
      chk("run.cpu_cs_o", cpu_cs_w[0], 0);
      chk("run.eng_cs_o", eng_cs_w[0], 1);
      idle();
      ctrl_wr(8'h01);
      rd(0, 2'd1, "run.start_ign", 8'h02);
      rst = 1'b0;
      tick();
      idle();
      chk("rst.sel", sel_w[0], 0);
      chk("rst.start", start_w[0], 0);
      rd(0, 2'd1, "rst.status", 8'h00);
      tick();
      chk("rst.no_start", start_w[0], 0);

      // completion with interrupt enabled
      ctrl_wr(8'h05);
      tick();
      for (int c = 0; c < 19; c++) tick();
      done_pulse();
      chk("done.sel", sel_w[0], 0);
      chk("done.irq", irq_w[0], 1);
      rd(0, 2'd1, "done.status", 8'h0B);
      rd(0, 2'd0, "done.ctrl", 8'h04);
      ctrl_wr(8'h06);
      rd(0, 2'd1, "ack.status", 8'h00);
      chk("ack.irq", irq_w[0], 0);

      // watchdog expiry on the TIMEOUT=16 instance
      ctrl_wr(8'h01);
      for (int c = 0; c < 16; c++) tick();
      rd(1, 2'd1, "wd.still_run", 8'h02);
      tick();
      rd(1, 2'd1, "wd.status", 8'h1C);
      rd(0, 2'd1, "wd.a_run", 8'h02);
      ctrl_wr(8'h02);
      rd(1, 2'd1, "wd.ack", 8'h00);
      done_pulse();
      ctrl_wr(8'h02);

      // fill_flag and START in the same cycle
      pulses = 0;
      cpu_cs = 1; cpu_we = 1; cpu_addr = 10'h3FF; fill_flag = 1;
      ctrl_cs = 1; ctrl_we = 1; ctrl_data_i = 8'h01;
      for (int c = 0; c < 5; c++) begin
         tick();
         idle();
         if (start_w[0]) pulses++;
      end
      chk("both.pulses", pulses, 1);
      done_pulse();
      ctrl_wr(8'h02);

      for (int c = 0; c < 4000; c++) begin
         rst = ($urandom_range(0, 199) != 0);
         cpu_cs = $urandom_range(0, 1);
         cpu_we = $urandom_range(0, 1);
         cpu_addr = 10'($urandom_range(0, 1023));
         fill_flag = ($urandom_range(0, 63) == 0);
         eng_cs = $urandom_range(0, 1);
         eng_we = $urandom_range(0, 1);
         eng_done = ($urandom_range(0, 23) == 0);
         ctrl_cs = ($urandom_range(0, 7) == 0);
         ctrl_we = $urandom_range(0, 1);
         ctrl_addr = 2'($urandom_range(0, 3));
         ctrl_data_i = 8'($urandom_range(0, 255));
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
